// File: rtl/voice_cmd_rx.sv
// UART (8N1) command receiver for the voice-controlled line follower: decodes
// ASCII command letters into a 3-bit code. Define VOICE_CMD_TIMEOUT_EN to build the link watchdog.
module voice_cmd_rx #(
    parameter int CLKS_PER_BIT   = 5208,
    parameter int TIMEOUT_CYCLES = 100_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [2:0] cmd,
    output logic       cmd_valid,
    output logic       bad_cmd,
    output logic       frame_err,
    output logic       link_timeout
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] HALF_LAST = BAUD_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [2:0] CMD_AUTO = 3'b000;
    localparam logic [2:0] CMD_STOP = 3'b100;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } state_t;

    state_t            state_q, state_d;
    logic              rx_meta_q, rx_sync_q;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [7:0]        shift_q, shift_d;
    logic [2:0]        cmd_q, cmd_d;
    logic              cmd_valid_q, cmd_valid_d;
    logic              bad_cmd_q, bad_cmd_d;
    logic              frame_err_q, frame_err_d;
    logic              good_frame;
    logic              load_cmd;
    logic [3:0]        dec;

    // Returns {hit, code}; only upper-case letters are recognised.
    function automatic logic [3:0] decode_byte(input logic [7:0] b);
        logic [3:0] r;
        case (b)
            8'h41:   r = {1'b1, 3'b000};
            8'h46:   r = {1'b1, 3'b001};
            8'h52:   r = {1'b1, 3'b010};
            8'h4C:   r = {1'b1, 3'b011};
            8'h53:   r = {1'b1, 3'b100};
            8'h42:   r = {1'b1, 3'b101};
            default: r = 4'b0000;
        endcase
        return r;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q   <= 1'b1;
            rx_sync_q   <= 1'b1;
            state_q     <= IDLE;
            baud_q      <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            cmd_q       <= CMD_AUTO;
            cmd_valid_q <= 1'b0;
            bad_cmd_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            rx_meta_q   <= rx;
            rx_sync_q   <= rx_meta_q;
            state_q     <= state_d;
            baud_q      <= baud_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            cmd_q       <= cmd_d;
            cmd_valid_q <= cmd_valid_d;
            bad_cmd_q   <= bad_cmd_d;
            frame_err_q <= frame_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        baud_d      = baud_q + 1'b1;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        good_frame  = 1'b0;
        frame_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                baud_d = '0;
                if (!rx_sync_q) begin
                    state_d   = START;
                    bit_cnt_d = '0;
                end
            end
            START: begin
                // Mid-start-bit recheck filters short glitches on the line.
                if (baud_q == HALF_LAST) begin
                    baud_d  = '0;
                    state_d = rx_sync_q ? IDLE : DATA;
                end
            end
            DATA: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d  = '0;
                    shift_d = {rx_sync_q, shift_q[7:1]};
                    if (bit_cnt_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            STOP: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d = '0;
                    if (rx_sync_q) begin
                        good_frame = 1'b1;
                        state_d    = IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        shift_d     = '0;
                        state_d     = WAIT_HIGH;
                    end
                end
            end
            WAIT_HIGH: begin
                baud_d = '0;
                if (rx_sync_q) begin
                    state_d = IDLE;
                end
            end
            default: begin
                baud_d  = '0;
                state_d = IDLE;
            end
        endcase
    end

    assign dec         = decode_byte(shift_q);
    assign load_cmd    = good_frame & dec[3];
    assign cmd_valid_d = load_cmd;
    assign bad_cmd_d   = good_frame & ~dec[3];

`ifdef VOICE_CMD_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES);

    logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
    logic            link_timeout_q, link_timeout_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt_q       <= '0;
            link_timeout_q <= 1'b0;
        end else begin
            wd_cnt_q       <= wd_cnt_d;
            link_timeout_q <= link_timeout_d;
        end
    end

    // A freshly decoded command takes priority over a simultaneous expiry.
    always_comb begin
        cmd_d          = cmd_q;
        wd_cnt_d       = wd_cnt_q;
        link_timeout_d = link_timeout_q;
        if (load_cmd) begin
            cmd_d          = dec[2:0];
            wd_cnt_d       = '0;
            link_timeout_d = 1'b0;
        end else if (cmd_q == CMD_AUTO) begin
            wd_cnt_d = '0;
        end else if (!link_timeout_q) begin
            if (wd_cnt_q == WD_LIMIT) begin
                cmd_d          = CMD_STOP;
                link_timeout_d = 1'b1;
            end else begin
                wd_cnt_d = wd_cnt_q + 1'b1;
            end
        end
    end

    assign link_timeout = link_timeout_q;
`else
    always_comb begin
        cmd_d = cmd_q;
        if (load_cmd) begin
            cmd_d = dec[2:0];
        end
    end

    assign link_timeout = 1'b0;
`endif

    assign cmd       = cmd_q;
    assign cmd_valid = cmd_valid_q;
    assign bad_cmd   = bad_cmd_q;
    assign frame_err = frame_err_q;

endmodule

// File: doc/voice_cmd_rx.md
# voice_cmd_rx

Serial front end for the voice-controlled line follower. Receives 8N1 UART bytes from the voice-recognition module, decodes ASCII command letters into the 3-bit `cmd` code consumed directly downstream by the line-follower motor logic, and holds that code until the next valid command. An optional link watchdog forces STOP when the voice link goes silent while in a voice mode.

## Interface
- `CLKS_PER_BIT`, 5208, clock cycles per UART bit (50 MHz / 9600 baud); minimum 8.
- `TIMEOUT_CYCLES`, 100_000_000, idle cycles (2 s at 50 MHz) before the watchdog fires; minimum 2.

- `clk`  in  1  system clock; one clock domain.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `rx`  in  1  UART serial input from the voice module; idle high; asynchronous to `clk`.
- `cmd`  out  3  registered command code to the line-follower logic.
- `cmd_valid`  out  1  one-cycle pulse when `cmd` is loaded from a received byte.
- `bad_cmd`  out  1  one-cycle pulse when a well-framed byte is not a known command.
- `frame_err`  out  1  one-cycle pulse when the stop bit samples low.
- `link_timeout`  out  1  level; high while the watchdog-forced STOP is in effect.

## Operation
- `rx` passes through a 2-flop synchronizer; all FSM logic uses the synchronized value.
- Receiver FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
  - IDLE: a synchronized low moves to START and clears the bit counter.
  - START: at CLKS_PER_BIT/2 cycles, sample. Low goes to DATA; high is a false start and returns to IDLE with no pulse.
  - DATA: sample every CLKS_PER_BIT cycles, 8 bits, LSB first, shifted into the byte register.
  - STOP: sample after CLKS_PER_BIT cycles. High is a good frame and goes to IDLE. Low pulses `frame_err`, discards the byte, and goes to WAIT_HIGH.
  - WAIT_HIGH: stay until synchronized `rx` is high, then go to IDLE. This rejects break or stuck-low lines.
- Decode on a good frame:
  - 0x41 'A' → 000, auto
  - 0x46 'F' → 001, forward
  - 0x52 'R' → 010, right
  - 0x4C 'L' → 011, left
  - 0x53 'S' → 100, stop
  - 0x42 'B' → 101, reverse
  - Upper case only. Any other byte pulses `bad_cmd`, and `cmd` is unchanged.
- A valid command loads `cmd`, pulses `cmd_valid`, clears `link_timeout`, and clears the watchdog counter. Reloading the same code still pulses `cmd_valid`.
- Watchdog behaviour:
  - Counts only while `cmd` ≠ 000 and `link_timeout` = 0.
  - Is held at 0 while `cmd` = 000.
  - Is not cleared by `bad_cmd` or `frame_err`.
  - When the count reaches TIMEOUT_CYCLES, `cmd` is forced to 100 and `link_timeout` is set. No `cmd_valid` pulse is generated.

## Timing
- Reset values:
  - `cmd` = 000; `cmd_valid`, `bad_cmd`, `frame_err`, `link_timeout` = 0.
  - FSM in IDLE; shift register, bit counter, baud counter and watchdog counter = 0.
- Reset asserted mid-frame aborts the frame. After release, the first synchronized falling edge starts a new frame.
- Latency:
  - `rx` falling edge to START entry: 2 cycles (synchronizer).
  - Stop-bit sample cycle to `cmd` / `cmd_valid` / `bad_cmd`: 1 cycle (registered decode).
- `frame_err` asserts in the cycle after the stop-bit sample.
- A new frame can start in the cycle after the STOP → IDLE transition (back-to-back bytes supported).
- The watchdog fires exactly TIMEOUT_CYCLES cycles after the last `cmd_valid` in a voice mode. `cmd` changes in the next cycle.
- If a valid command decodes in the same cycle as watchdog expiry, the command wins: `cmd` takes the decoded code, `link_timeout` stays 0, and the counter clears.
- The watchdog counter saturates; it never wraps.

## Configuration
- `VOICE_CMD_TIMEOUT_EN` defined: the watchdog is built as described.
- `VOICE_CMD_TIMEOUT_EN` undefined:
  - No watchdog counter is synthesized.
  - `link_timeout` is tied 0.
  - `cmd` holds the last valid command indefinitely.
  - TIMEOUT_CYCLES is ignored.

## Test plan
Bench parameters: CLKS_PER_BIT=16, TIMEOUT_CYCLES=1000, macro defined unless stated.
- Reset, then send 0x46 → `cmd`=001, one `cmd_valid` pulse 1 cycle after the stop sample. Then send 0x52, 0x4C, 0x42, 0x53 back-to-back → `cmd` = 010, 011, 101, 100 in order, with 4 pulses.
- Send 0x58 'X' while `cmd`=011 → `bad_cmd` pulses once; `cmd` stays 011; no `cmd_valid`.
- Send 0x46 with the stop bit driven low, then hold `rx` low for 100 cycles, then release → one `frame_err` pulse; `cmd` unchanged; the next 0x41 decodes to 000.
- Send 0x46, then idle 1000 cycles → `cmd`=100 and `link_timeout`=1. Send 0x41 → `cmd`=000, `link_timeout`=0. Idle 2000 cycles → `cmd` stays 000.
- 8-cycle low glitch on `rx`, then assert `rst_n`=0 mid-way through a 0x52 frame → no outputs from the glitch; after the reset, all outputs are 0 and `cmd`=000; the next 0x52 decodes to 010.
- Macro undefined: send 0x46, idle 5000 cycles → `cmd` stays 001 and `link_timeout` stays 0.
